fifo_word_packer: RTL and testbench

Downstream consumer of the 16x8 synchronous FIFO. Pops bytes through the FIFO's read/empty/d_out port and packs BYTES consecutive bytes into one wide word. Presents the word on a valid/ready master interface toward the next stage (bus write or DMA). A flush request emits a zero-padded partial word so trailing bytes are never stranded.

---
 rtl/fifo_word_packer.sv | 116 +++++++++++
 tb/tb_fifo_word_packer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_word_packer.sv
// fifo_word_packer: pops bytes from a one-cycle-latency FIFO read port and packs
// BYTES consecutive bytes into one word on a valid/ready master port.
// A flush emits a zero-padded partial word so trailing bytes are never stranded.
// Build option: define PACKER_MSB_FIRST_EN to place the first popped byte in the
// most-significant lane (partial words left-justified). Default is LSB-first.
module fifo_word_packer #(
    parameter int D_width = 8,
    parameter int BYTES   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fifo_empty,
    input  logic [D_width-1:0]       fifo_dout,
    output logic                     fifo_read,
    input  logic                     flush,
    output logic [D_width*BYTES-1:0] m_data,
    output logic [3:0]               m_bytes,
    output logic                     m_valid,
    input  logic                     m_ready
);

    localparam logic [3:0] NB = 4'(BYTES);

    typedef enum logic {FILL, OUT} state_t;

    state_t                   state_q, state_d;
    logic [3:0]               issued_q, issued_d;
    logic [3:0]               captured_q, captured_d;
    logic [3:0]               bytes_q, bytes_d;
    logic                     pend_q;
    logic                     flush_pend_q, flush_pend_d;
    logic [D_width*BYTES-1:0] data_q, data_d;
    logic [3:0]               lane;

    // Lane that the next captured byte lands in; counting down from the top
    // lane in MSB-first mode leaves partial words left-justified for free.
    always_comb begin
`ifdef PACKER_MSB_FIRST_EN
        lane = NB - 4'd1 - captured_q;
`else
        lane = captured_q;
`endif
    end

    // Next-state logic: launch reads, capture returning bytes, decide when to emit.
    always_comb begin
        state_d      = state_q;
        issued_d     = issued_q;
        captured_d   = captured_q;
        flush_pend_d = flush_pend_q;
        data_d       = data_q;
        bytes_d      = bytes_q;
        fifo_read    = 1'b0;
        case (state_q)
            FILL: begin
                // Reads stream back-to-back; a pending flush stops new reads so
                // only the byte already in flight still lands.
                fifo_read = !reset && !fifo_empty && (issued_q < NB) && !flush_pend_q;
                if (fifo_read)
                    issued_d = issued_q + 4'd1;
                // issued==0 implies captured==0, so this ignores empty flushes.
                if (flush && (issued_q != 4'd0))
                    flush_pend_d = 1'b1;
                if (pend_q) begin
                    data_d[int'(lane)*D_width +: D_width] = fifo_dout;
                    captured_d = captured_q + 4'd1;
                    if (captured_q == NB - 4'd1) begin
                        state_d = OUT;
                        bytes_d = NB;
                    end
                end else if (flush_pend_q && (captured_q != 4'd0)) begin
                    state_d = OUT;
                    bytes_d = captured_q;
                end
            end
            OUT: begin
                // Word is held until accepted; flush requests here are dropped.
                if (m_ready) begin
                    state_d      = FILL;
                    issued_d     = 4'd0;
                    captured_d   = 4'd0;
                    flush_pend_d = 1'b0;
                    data_d       = '0;
                    bytes_d      = 4'd0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // State registers; reset discards any partial word and in-flight byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FILL;
            issued_q     <= 4'd0;
            captured_q   <= 4'd0;
            bytes_q      <= 4'd0;
            pend_q       <= 1'b0;
            flush_pend_q <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            issued_q     <= issued_d;
            captured_q   <= captured_d;
            bytes_q      <= bytes_d;
            pend_q       <= fifo_read;
            flush_pend_q <= flush_pend_d;
            data_q       <= data_d;
        end
    end

    assign m_valid = (state_q == OUT);
    assign m_data  = data_q;
    assign m_bytes = bytes_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: behavioural 1-cycle-latency FIFO, per-cycle logs,
// and a byte-stream reference that chunks pushed bytes into expected words.
module tb_fifo_word_packer;
    localparam int DW = 8;
    localparam int NB = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            fifo_empty;
    logic [DW-1:0]   fifo_dout = '0;
    logic            fifo_read;
    logic            flush = 1'b0;
    logic [DW*NB-1:0] m_data;
    logic [3:0]      m_bytes;
    logic            m_valid;
    logic            m_ready = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [7:0] fmem [0:4095];
    int wr_cnt = 0;
    int rd_cnt = 0;

    bit rd_log  [0:8191];
    bit vld_log [0:8191];
    logic [31:0] hs_data [$];
    logic [3:0]  hs_bytes [$];
    int          hs_cyc [$];
    int rd_empty_viol = 0;
    int drop_viol = 0;
    logic prev_vld = 1'b0, prev_hs = 1'b0, prev_rst = 1'b1;

    fifo_word_packer #(.D_width(DW), .BYTES(NB)) dut (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_read(fifo_read), .flush(flush), .m_data(m_data), .m_bytes(m_bytes),
        .m_valid(m_valid), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wr_cnt == rd_cnt);

    // FIFO model: registered read data, cleared by the shared reset.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) rd_cnt <= wr_cnt;
        else if (fifo_read && (wr_cnt != rd_cnt)) begin
            fifo_dout <= fmem[rd_cnt];
            rd_cnt <= rd_cnt + 1;
        end
    end

    // Mid-cycle monitor: logs reads/valid, records handshakes, tracks protocol breaks.
    always @(negedge clk) begin
        if (cyc < 8192) begin
            rd_log[cyc]  <= fifo_read;
            vld_log[cyc] <= m_valid;
        end
        if (fifo_read && fifo_empty) rd_empty_viol <= rd_empty_viol + 1;
        if (prev_vld && !prev_hs && !prev_rst && !m_valid) drop_viol <= drop_viol + 1;
        if (m_valid && m_ready && !reset) begin
            hs_data.push_back(m_data);
            hs_bytes.push_back(m_bytes);
            hs_cyc.push_back(cyc);
        end
        prev_vld <= m_valid;
        prev_hs  <= m_valid && m_ready;
        prev_rst <= reset;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        fmem[wr_cnt] = b;
        wr_cnt++;
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; m_ready = 1'b0;
        tick(1);
        reset = 1'b0;
    endtask

    // Expected word: byte i of the stream goes to lane i (or mirrored lane).
    function automatic logic [31:0] pack(input logic [7:0] b[$], input int n);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < n; i++) begin
`ifdef PACKER_MSB_FIRST_EN
            w[8*(NB-1-i) +: 8] = b[i];
`else
            w[8*i +: 8] = b[i];
`endif
        end
        return w;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        push(8'h99);
        #1;
        n_checks++; if (fifo_read !== 1'b0) begin n_fail++; $display("FAIL rst_read: got %b want 0", fifo_read); end
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", m_valid); end
        n_checks++; if (m_data !== '0) begin n_fail++; $display("FAIL rst_data: got %h want 0", m_data); end
        n_checks++; if (m_bytes !== 4'd0) begin n_fail++; $display("FAIL rst_bytes: got %0d want 0", m_bytes); end
        tick(1);
        reset = 1'b0;
    endtask

    task automatic test_full_word();
        logic [7:0] bq[$];
        int c0, base;
        do_reset();
        m_ready = 1'b1; c0 = cyc; base = hs_data.size();
        for (int i = 0; i < 4; i++) begin bq.push_back(8'(8'h11 * (i + 1))); push(bq[i]); end
        tick(10);
        for (int c = c0; c < c0 + 10; c++) begin
            n_checks++; if (rd_log[c] !== (c < c0 + 4)) begin n_fail++; $display("FAIL full_read cyc+%0d: got %b want %b", c - c0, rd_log[c], (c < c0 + 4)); end
            n_checks++; if (vld_log[c] !== (c == c0 + 5)) begin n_fail++; $display("FAIL full_valid cyc+%0d: got %b want %b", c - c0, vld_log[c], (c == c0 + 5)); end
        end
        n_checks++; if (hs_data.size() !== base + 1) begin n_fail++; $display("FAIL full_count: got %0d want %0d", hs_data.size() - base, 1); end
        else begin
            n_checks++; if (hs_data[base] !== pack(bq, 4)) begin n_fail++; $display("FAIL full_data: got %h want %h", hs_data[base], pack(bq, 4)); end
            n_checks++; if (hs_bytes[base] !== 4'd4) begin n_fail++; $display("FAIL full_bytes: got %0d want 4", hs_bytes[base]); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] bq[$];
        logic [7:0] hi[$];
        int base, k;
        do_reset();
        base = hs_data.size();
        for (int i = 0; i < 8; i++) begin
            push(8'(8'hAA + i));
            if (i < 4) bq.push_back(8'(8'hAA + i)); else hi.push_back(8'(8'hAA + i));
        end
        tick(6);
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid %0d: got %b want 1", i, m_valid); end
            n_checks++; if (m_data !== pack(bq, 4)) begin n_fail++; $display("FAIL bp_hold_data %0d: got %h want %h", i, m_data, pack(bq, 4)); end
            n_checks++; if (fifo_read !== 1'b0) begin n_fail++; $display("FAIL bp_no_read %0d: got %b want 0", i, fifo_read); end
            tick(1);
        end
        m_ready = 1'b1; k = cyc;
        tick(1);
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_after_hs: got %b want 0", m_valid); end
        for (int i = 0; i < 30 && hs_data.size() < base + 2; i++) tick(1);
        n_checks++; if (hs_data.size() !== base + 2) begin n_fail++; $display("FAIL bp_timeout: got %0d words want 2", hs_data.size() - base); end
        else begin
            n_checks++; if (hs_cyc[base] !== k) begin n_fail++; $display("FAIL bp_hs1_cyc: got %0d want %0d", hs_cyc[base], k); end
            n_checks++; if (hs_data[base+1] !== pack(hi, 4)) begin n_fail++; $display("FAIL bp_word2: got %h want %h", hs_data[base+1], pack(hi, 4)); end
            n_checks++; if (hs_cyc[base+1] !== k + 6) begin n_fail++; $display("FAIL bp_word2_cyc: got +%0d want +6", hs_cyc[base+1] - k); end
        end
    endtask

    task automatic test_flush_partial();
        logic [7:0] bq[$];
        logic [7:0] nq[$];
        int base, f;
        do_reset();
        m_ready = 1'b1; base = hs_data.size();
        bq.push_back(8'h5A); bq.push_back(8'h6B);
        push(8'h5A); push(8'h6B);
        tick(4);
        flush = 1'b1; f = cyc;
        tick(1);
        flush = 1'b0;
        for (int i = 0; i < 20 && hs_data.size() < base + 1; i++) tick(1);
        n_checks++; if (hs_data.size() !== base + 1) begin n_fail++; $display("FAIL flush_timeout: got %0d words want 1", hs_data.size() - base); end
        else begin
            n_checks++; if (hs_cyc[base] !== f + 2) begin n_fail++; $display("FAIL flush_latency: got +%0d want +2", hs_cyc[base] - f); end
            n_checks++; if (hs_data[base] !== pack(bq, 2)) begin n_fail++; $display("FAIL flush_data: got %h want %h", hs_data[base], pack(bq, 2)); end
            n_checks++; if (hs_bytes[base] !== 4'd2) begin n_fail++; $display("FAIL flush_bytes: got %0d want 2", hs_bytes[base]); end
        end
        tick(2);
        base = hs_data.size();
        flush = 1'b1; tick(1); flush = 1'b0;
        tick(8);
        n_checks++; if (hs_data.size() !== base) begin n_fail++; $display("FAIL flush_empty: got %0d words want 0", hs_data.size() - base); end
        for (int i = 0; i < 4; i++) begin nq.push_back(8'($urandom)); push(nq[i]); end
        for (int i = 0; i < 20 && hs_data.size() < base + 1; i++) tick(1);
        n_checks++; if (hs_data.size() !== base + 1) begin n_fail++; $display("FAIL flush_empty_next: got %0d words want 1", hs_data.size() - base); end
        else begin
            n_checks++; if (hs_data[base] !== pack(nq, 4)) begin n_fail++; $display("FAIL flush_next_data: got %h want %h", hs_data[base], pack(nq, 4)); end
        end
    endtask

    task automatic test_flush_inflight();
        logic [7:0] bq[$];
        int base, c0;
        do_reset();
        m_ready = 1'b1; base = hs_data.size(); c0 = cyc;
        for (int i = 0; i < 4; i++) begin bq.push_back(8'($urandom_range(1, 255))); push(bq[i]); end
        tick(2);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        for (int i = 0; i < 20 && hs_data.size() < base + 1; i++) tick(1);
        for (int c = c0; c < c0 + 6; c++) begin
            n_checks++; if (rd_log[c] !== (c < c0 + 3)) begin n_fail++; $display("FAIL infl_read cyc+%0d: got %b want %b", c - c0, rd_log[c], (c < c0 + 3)); end
        end
        n_checks++; if (hs_data.size() < base + 1) begin n_fail++; $display("FAIL infl_timeout: got %0d words want 1", hs_data.size() - base); end
        else begin
            n_checks++; if (hs_bytes[base] !== 4'd3) begin n_fail++; $display("FAIL infl_bytes: got %0d want 3", hs_bytes[base]); end
            n_checks++; if (hs_data[base] !== pack(bq, 3)) begin n_fail++; $display("FAIL infl_data: got %h want %h", hs_data[base], pack(bq, 3)); end
            n_checks++; if (hs_cyc[base] !== c0 + 5) begin n_fail++; $display("FAIL infl_cyc: got +%0d want +5", hs_cyc[base] - c0); end
        end
    endtask

    task automatic test_starvation();
        logic [7:0] bq[$];
        int base, c0, v0;
        bit exp;
        do_reset();
        m_ready = 1'b1; base = hs_data.size(); c0 = cyc; v0 = rd_empty_viol;
        for (int i = 0; i < 4; i++) begin
            bq.push_back(8'($urandom)); push(bq[i]);
            tick(7);
        end
        for (int c = c0; c < c0 + 28; c++) begin
            exp = ((c - c0) % 7 == 0) && (c - c0 < 22);
            n_checks++; if (rd_log[c] !== exp) begin n_fail++; $display("FAIL starve_read cyc+%0d: got %b want %b", c - c0, rd_log[c], exp); end
        end
        n_checks++; if (rd_empty_viol !== v0) begin n_fail++; $display("FAIL starve_read_empty: got %0d want %0d", rd_empty_viol, v0); end
        n_checks++; if (hs_data.size() !== base + 1) begin n_fail++; $display("FAIL starve_count: got %0d want 1", hs_data.size() - base); end
        else begin
            n_checks++; if (hs_data[base] !== pack(bq, 4)) begin n_fail++; $display("FAIL starve_data: got %h want %h", hs_data[base], pack(bq, 4)); end
            n_checks++; if (hs_cyc[base] !== c0 + 23) begin n_fail++; $display("FAIL starve_cyc: got +%0d want +23", hs_cyc[base] - c0); end
        end
    endtask

    task automatic test_reset_midword();
        logic [7:0] nq[$];
        int base;
        do_reset();
        m_ready = 1'b1; base = hs_data.size();
        for (int i = 0; i < 4; i++) push(8'hE0 + 8'(i));
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", m_valid); end
        n_checks++; if (m_data !== '0) begin n_fail++; $display("FAIL midrst_data: got %h want 0", m_data); end
        for (int i = 0; i < 4; i++) begin nq.push_back(8'($urandom)); push(nq[i]); end
        for (int i = 0; i < 20 && hs_data.size() < base + 1; i++) tick(1);
        tick(3);
        n_checks++; if (hs_data.size() !== base + 1) begin n_fail++; $display("FAIL midrst_count: got %0d want 1", hs_data.size() - base); end
        else begin
            n_checks++; if (hs_data[base] !== pack(nq, 4)) begin n_fail++; $display("FAIL midrst_word: got %h want %h", hs_data[base], pack(nq, 4)); end
        end
    endtask

    task automatic test_random();
        logic [7:0] stream[$];
        logic [7:0] w[$];
        logic [7:0] b;
        int base, sent, total;
        do_reset();
        base = hs_data.size(); sent = 0; total = 64;
        for (int i = 0; i < 3000 && (sent < total || hs_data.size() < base + total / 4); i++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            if (sent < total && (wr_cnt - rd_cnt) < 16 && $urandom_range(0, 2) != 0) begin
                b = 8'($urandom); push(b); stream.push_back(b); sent++;
            end
            tick(1);
        end
        m_ready = 1'b0;
        n_checks++; if (hs_data.size() !== base + total / 4) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", hs_data.size() - base, total / 4); end
        else begin
            for (int k = 0; k < total / 4; k++) begin
                w.delete();
                for (int j = 0; j < 4; j++) w.push_back(stream[4*k + j]);
                n_checks++; if (hs_data[base+k] !== pack(w, 4) || hs_bytes[base+k] !== 4'd4) begin
                    n_fail++; $display("FAIL rand_word %0d: got %h/%0d want %h/4", k, hs_data[base+k], hs_bytes[base+k], pack(w, 4));
                end
            end
        end
    endtask

    task automatic test_invariants();
        n_checks++; if (rd_empty_viol !== 0) begin n_fail++; $display("FAIL read_while_empty: got %0d want 0", rd_empty_viol); end
        n_checks++; if (drop_viol !== 0) begin n_fail++; $display("FAIL valid_dropped: got %0d want 0", drop_viol); end
    endtask

    initial begin
        tick(1);
        test_reset();
        test_full_word();
        test_backpressure();
        test_flush_partial();
        test_flush_inflight();
        test_starvation();
        test_reset_midword();
        test_random();
        test_invariants();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog");
    end
endmodule
